// File: rtl/gps_pkg.sv
// gps_pkg
// Shared definitions for the GPS-disciplined gate sequencer: the gate FSM
// state encoding, the glitch counter width and the default timing constants
// for a 10 MHz system clock (8 M cycles minimum PPS spacing, 12 M cycles
// before PPS is declared missing).
package gps_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } gate_state_t;

    localparam int unsigned GLITCH_COUNT_WIDTH        = 8;
    localparam int unsigned CFG_AVERAGE_WIDTH         = 4;
    localparam int unsigned DEFAULT_TIMER_WIDTH       = 25;
    localparam int unsigned DEFAULT_MIN_PERIOD_CYCLES = 8_000_000;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES    = 12_000_000;

endpackage

// File: rtl/pulse_synchronizer.sv
// pulse_synchronizer
// Brings an asynchronous level into the system_clk domain through two
// flip-flops, then keeps one more registered copy so a rising edge can be
// flagged for exactly one cycle.
//
// Ports:
//   system_clk - sampling clock (rising edge)
//   rst_n      - asynchronous active-low reset, clears all stages
//   i_async    - raw asynchronous input
//   o_rise     - one-cycle pulse on a synchronised 0->1 transition
module pulse_synchronizer (
    input  logic system_clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Two-stage synchroniser followed by the delayed copy used for edge detect.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/gps_gate_controller.sv
// gps_gate_controller
// Opens and closes frequency-measurement gates spanning (cfg_average + 1)
// PPS intervals, rejects PPS edges that arrive too soon after the last
// accepted one, flags a missing PPS, and hands latched results to the SPI
// side with a ready/ack handshake plus overrun detection.
//
// Ports:
//   system_clk, rst_n  - clock and asynchronous active-low reset
//   gps_pulse          - raw PPS pin (asynchronous)
//   enable             - measurement run enable (level)
//   cfg_average        - gate length minus one, in PPS intervals
//   cfg_load           - strobe capturing cfg_average into the shadow register
//   result_ack         - strobe: SPI side has read the result
//   status_clear       - strobe clearing overrun, pps_missing, glitch_count
//   counter_enable     - reference counter runs while high
//   counter_clear      - one-cycle pulse zeroing the reference counter
//   counter_latch      - one-cycle pulse copying the counter into the result
//   result_ready       - a latched result awaits readout
//   overrun            - sticky: result overwritten before ack
//   pps_missing        - sticky: PPS timeout expired during a gate
//   glitch_count       - saturating count of rejected edges
//   state              - current FSM state (IDLE=0, ARM=1, MEASURE=2)
module gps_gate_controller
    import gps_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH       = DEFAULT_TIMER_WIDTH,
    parameter int unsigned MIN_PERIOD_CYCLES = DEFAULT_MIN_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          system_clk,
    input  logic                          rst_n,
    input  logic                          gps_pulse,
    input  logic                          enable,
    input  logic [CFG_AVERAGE_WIDTH-1:0]  cfg_average,
    input  logic                          cfg_load,
    input  logic                          result_ack,
    input  logic                          status_clear,
    output logic                          counter_enable,
    output logic                          counter_clear,
    output logic                          counter_latch,
    output logic                          result_ready,
    output logic                          overrun,
    output logic                          pps_missing,
    output logic [GLITCH_COUNT_WIDTH-1:0] glitch_count,
    output logic [1:0]                    state
);

    localparam logic [TIMER_WIDTH-1:0] MIN_T     = TIMER_WIDTH'(MIN_PERIOD_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_T = TIMER_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

    gate_state_t                    r_state;
    gate_state_t                    w_state_next;
    logic [TIMER_WIDTH-1:0]         r_timer;
    logic [CFG_AVERAGE_WIDTH-1:0]   r_shadow;
    logic [CFG_AVERAGE_WIDTH-1:0]   r_active_avg;
    logic [CFG_AVERAGE_WIDTH-1:0]   r_edge_count;
    logic [CFG_AVERAGE_WIDTH-1:0]   w_active_next;
    logic [CFG_AVERAGE_WIDTH-1:0]   w_edge_count_next;
    logic                           r_counter_enable;
    logic                           r_counter_clear;
    logic                           r_counter_latch;
    logic                           w_clear_next;
    logic                           w_latch_next;
    logic                           r_ready;
    logic                           r_overrun;
    logic                           r_pps_missing;
    logic [GLITCH_COUNT_WIDTH-1:0]  r_glitch_count;
    logic                           w_pps_edge;
    logic                           w_accept;
    logic                           w_glitch;
    logic                           w_timeout;

    pulse_synchronizer u_pps_sync (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .i_async    (gps_pulse),
        .o_rise     (w_pps_edge)
    );

    // While arming any edge starts the gate; once measuring, an edge must
    // arrive at least MIN_PERIOD_CYCLES after the previous accepted one or it
    // is treated as a glitch. An edge arriving on the timeout cycle itself is
    // accepted, so the timeout only fires when no edge is present.
    assign w_accept  = w_pps_edge && ((r_state == ST_ARM) ||
                       ((r_state == ST_MEASURE) && (r_timer >= MIN_T)));
    assign w_glitch  = w_pps_edge && (r_state == ST_MEASURE) && (r_timer < MIN_T);
    assign w_timeout = enable && (r_state == ST_MEASURE) && !w_accept &&
                       (r_timer == TIMEOUT_T);

    // Interval timer: counts cycles since the last accepted edge, saturating,
    // and parked at zero while idle.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if ((r_state == ST_IDLE) || w_accept) begin
            r_timer <= '0;
        end else if (r_timer != TIMER_MAX) begin
            r_timer <= r_timer + TIMER_WIDTH'(1);
        end
    end

    // Next-state and strobe decode. Dropping enable wins over everything and
    // discards the partial gate; the gate length is taken from the shadow
    // register only when a gate starts or a boundary is reached.
    always_comb begin
        w_state_next      = r_state;
        w_clear_next      = 1'b0;
        w_latch_next      = 1'b0;
        w_active_next     = r_active_avg;
        w_edge_count_next = r_edge_count;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_ARM;
                end
                ST_ARM: begin
                    if (w_accept) begin
                        w_clear_next      = 1'b1;
                        w_edge_count_next = '0;
                        w_active_next     = r_shadow;
                        w_state_next      = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (w_accept) begin
                        if (r_edge_count == r_active_avg) begin
                            w_latch_next      = 1'b1;
                            w_clear_next      = 1'b1;
                            w_edge_count_next = '0;
                            w_active_next     = r_shadow;
                        end else begin
                            w_edge_count_next = r_edge_count + CFG_AVERAGE_WIDTH'(1);
                        end
                    end else if (w_timeout) begin
                        w_state_next = ST_ARM;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, gate bookkeeping and registered counter controls.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_counter_enable <= 1'b0;
            r_counter_clear  <= 1'b0;
            r_counter_latch  <= 1'b0;
            r_edge_count     <= '0;
            r_active_avg     <= '0;
            r_shadow         <= '0;
        end else begin
            r_state          <= w_state_next;
            r_counter_enable <= (w_state_next == ST_MEASURE);
            r_counter_clear  <= w_clear_next;
            r_counter_latch  <= w_latch_next;
            r_edge_count     <= w_edge_count_next;
            r_active_avg     <= w_active_next;
            if (cfg_load) begin
                r_shadow <= cfg_average;
            end
        end
    end

    // Handshake: r_ready remembers an unread result. A latch while an older
    // result is still unread and unacknowledged in that same cycle is an
    // overrun; an ack coinciding with the latch retires only the old result.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_counter_latch) begin
                r_ready <= 1'b1;
            end else if (result_ack) begin
                r_ready <= 1'b0;
            end
            if (r_counter_latch && r_ready && !result_ack) begin
                r_overrun <= 1'b1;
            end else if (status_clear) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Sticky status: a fresh event in the same cycle as status_clear survives.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pps_missing  <= 1'b0;
            r_glitch_count <= '0;
        end else begin
            if (w_timeout) begin
                r_pps_missing <= 1'b1;
            end else if (status_clear) begin
                r_pps_missing <= 1'b0;
            end
            if (w_glitch) begin
                if (status_clear) begin
                    r_glitch_count <= GLITCH_COUNT_WIDTH'(1);
                end else if (r_glitch_count != '1) begin
                    r_glitch_count <= r_glitch_count + GLITCH_COUNT_WIDTH'(1);
                end
            end else if (status_clear) begin
                r_glitch_count <= '0;
            end
        end
    end

    // result_ready must already read high in the cycle the latch strobe is out.
    assign result_ready   = r_ready | r_counter_latch;
    assign counter_enable = r_counter_enable;
    assign counter_clear  = r_counter_clear;
    assign counter_latch  = r_counter_latch;
    assign overrun        = r_overrun;
    assign pps_missing    = r_pps_missing;
    assign glitch_count   = r_glitch_count;
    assign state          = r_state;

endmodule

// File: tb/tb_gps_gate_controller.sv
// tb_gps_gate_controller
// Directed walk through startup, glitch rejection, PPS timeout, overrun,
// configuration timing and abort, followed by a randomized run of PPS
// intervals, glitches, acks and config loads checked against an
// interval-counting reference model. Timing constants are scaled down
// (minimum spacing 80 cycles, timeout 120 cycles, PPS about every 100).
module tb_gps_gate_controller;

    localparam int TW      = 8;
    localparam int MIN_P   = 80;
    localparam int TMO     = 120;

    logic       system_clk = 1'b0;
    logic       rst_n;
    logic       gps_pulse;
    logic       enable;
    logic [3:0] cfg_average;
    logic       cfg_load;
    logic       result_ack;
    logic       status_clear;
    logic       counter_enable;
    logic       counter_clear;
    logic       counter_latch;
    logic       result_ready;
    logic       overrun;
    logic       pps_missing;
    logic [7:0] glitch_count;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;
    int latchCount = 0;

    gps_gate_controller #(
        .TIMER_WIDTH       (TW),
        .MIN_PERIOD_CYCLES (MIN_P),
        .TIMEOUT_CYCLES    (TMO)
    ) dut (
        .system_clk     (system_clk),
        .rst_n          (rst_n),
        .gps_pulse      (gps_pulse),
        .enable         (enable),
        .cfg_average    (cfg_average),
        .cfg_load       (cfg_load),
        .result_ack     (result_ack),
        .status_clear   (status_clear),
        .counter_enable (counter_enable),
        .counter_clear  (counter_clear),
        .counter_latch  (counter_latch),
        .result_ready   (result_ready),
        .overrun        (overrun),
        .pps_missing    (pps_missing),
        .glitch_count   (glitch_count),
        .state          (state)
    );

    // Free-running system clock.
    always #5 system_clk = ~system_clk;

    // Tally latch strobes on the falling edge to spot any unexpected latch.
    always @(negedge system_clk) begin
        if (counter_latch) latchCount++;
    end

    // Advance n clocks and settle just after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge system_clk);
            #1;
        end
    endtask

    // Raise the PPS pin for three cycles; returns in the cycle where the
    // resulting strobes are visible.
    task automatic applyStimulus();
        gps_pulse = 1'b1;
        tick(3);
        gps_pulse = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_state"}, state, 0);
        checkOutput({tag, "_cen"}, counter_enable, 0);
        checkOutput({tag, "_clr"}, counter_clear, 0);
        checkOutput({tag, "_lat"}, counter_latch, 0);
        checkOutput({tag, "_rdy"}, result_ready, 0);
        checkOutput({tag, "_ovr"}, overrun, 0);
        checkOutput({tag, "_miss"}, pps_missing, 0);
        checkOutput({tag, "_glitch"}, glitch_count, 0);
    endtask

    initial begin
        int  cnt;
        bit  sawLatch;
        int  l0;
        int  elapsed;
        int  gap;
        int  g;
        int  mShadow, mActive, mIntervals, mGlitch;
        bit  mInGate, mReady, mOverrun;
        bit  expClear, expLatch;

        rst_n = 1'b0; gps_pulse = 1'b0; enable = 1'b0; cfg_average = 4'd0;
        cfg_load = 1'b0; result_ack = 1'b0; status_clear = 1'b0;
        tick(3);
        checkAllZero("reset");
        rst_n = 1'b1;
        tick(2);
        checkOutput("idle_no_enable", state, 0);

        // Startup: gate of 3 intervals, first edge clears, fourth latches.
        enable = 1'b1; cfg_average = 4'd2; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        checkOutput("arm_state", state, 1);
        gps_pulse = 1'b1;
        tick(2);
        checkOutput("edge_latency_early", counter_clear, 0);
        tick();
        gps_pulse = 1'b0;
        checkOutput("start_clear", counter_clear, 1);
        checkOutput("start_no_latch", counter_latch, 0);
        checkOutput("start_state", state, 2);
        checkOutput("start_cen", counter_enable, 1);
        tick();
        checkOutput("clear_one_cycle", counter_clear, 0);
        tick(96);
        applyStimulus();
        checkOutput("edge2_no_latch", counter_latch, 0);
        checkOutput("edge2_no_clear", counter_clear, 0);
        tick(97);
        applyStimulus();
        checkOutput("edge3_no_latch", counter_latch, 0);
        tick(97);
        applyStimulus();
        checkOutput("edge4_latch", counter_latch, 1);
        checkOutput("edge4_clear", counter_clear, 1);
        checkOutput("edge4_ready", result_ready, 1);
        checkOutput("edge4_state", state, 2);
        tick();
        checkOutput("latch_one_cycle", counter_latch, 0);
        checkOutput("ready_holds", result_ready, 1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checkOutput("ready_after_ack", result_ready, 0);

        // Glitch 10 cycles after the accepted edge.
        tick(5);
        applyStimulus();
        checkOutput("glitch_count1", glitch_count, 1);
        checkOutput("glitch_no_clear", counter_clear, 0);
        tick(87);
        applyStimulus();
        checkOutput("post_glitch_e1", counter_latch, 0);
        tick(97);
        applyStimulus();
        checkOutput("post_glitch_e2", counter_latch, 0);
        tick(97);
        applyStimulus();
        checkOutput("post_glitch_latch", counter_latch, 1);

        // Timeout: no more pulses.
        cnt = 0;
        sawLatch = 1'b0;
        while (state == 2'd2 && cnt < 300) begin
            tick();
            cnt++;
            if (counter_latch) sawLatch = 1'b1;
        end
        checkOutput("timeout_cycles", cnt, TMO + 1);
        checkOutput("timeout_missing", pps_missing, 1);
        checkOutput("timeout_state", state, 1);
        checkOutput("timeout_cen", counter_enable, 0);
        checkOutput("timeout_no_latch", sawLatch, 0);
        checkOutput("no_overrun_yet", overrun, 0);

        // Prepare single-interval gates and clear status.
        cfg_average = 4'd0; cfg_load = 1'b1; result_ack = 1'b1; status_clear = 1'b1;
        tick();
        cfg_load = 1'b0; result_ack = 1'b0; status_clear = 1'b0;
        checkOutput("status_cleared_miss", pps_missing, 0);
        checkOutput("status_cleared_glitch", glitch_count, 0);
        checkOutput("acked_ready", result_ready, 0);
        tick(5);
        applyStimulus();
        checkOutput("resume_clear", counter_clear, 1);
        checkOutput("resume_no_latch", counter_latch, 0);
        checkOutput("resume_state", state, 2);
        tick(97);

        // Overrun: two latches without ack.
        applyStimulus();
        checkOutput("ovr_latch1", counter_latch, 1);
        tick();
        checkOutput("ovr_first_ok", overrun, 0);
        tick(96);
        applyStimulus();
        checkOutput("ovr_latch2", counter_latch, 1);
        tick();
        checkOutput("ovr_set", overrun, 1);
        status_clear = 1'b1;
        tick();
        status_clear = 1'b0;
        checkOutput("ovr_cleared", overrun, 0);
        tick(95);
        applyStimulus();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checkOutput("ack_in_latch_ready", result_ready, 1);
        checkOutput("ack_in_latch_ovr", overrun, 0);

        // Config timing: active 1, load 5 mid-gate.
        cfg_average = 4'd1; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick(95);
        applyStimulus();
        checkOutput("cfg_boundary_latch", counter_latch, 1);
        cfg_average = 4'd5; cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick(96);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus();
            checkOutput($sformatf("cfg_edge%0d", i), counter_latch,
                        (i == 2 || i == 8) ? 1 : 0);
            tick(97);
        end

        // Abort by enable.
        applyStimulus();
        tick(20);
        result_ack = 1'b1; status_clear = 1'b1;
        tick();
        result_ack = 1'b0; status_clear = 1'b0;
        enable = 1'b0;
        tick();
        checkAllZero("abort_en");
        l0 = latchCount;
        tick(76);
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            tick(97);
        end
        checkOutput("abort_en_no_latch", latchCount, l0);
        checkAllZero("abort_en_late");

        // Abort by asynchronous reset mid-gate.
        enable = 1'b1;
        tick();
        applyStimulus();
        tick(97);
        applyStimulus();
        tick(40);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("abort_rst");
        tick(4);
        rst_n = 1'b1;

        // Randomized run against the interval-counting model.
        mShadow = $urandom_range(0, 3);
        cfg_average = 4'(mShadow); cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick(2);
        mActive = 0; mIntervals = 0; mGlitch = 0;
        mInGate = 1'b0; mReady = 1'b0; mOverrun = 1'b0;
        applyStimulus();
        elapsed = 3;
        mInGate = 1'b1; mActive = mShadow;
        checkOutput("rnd_start_clear", counter_clear, 1);
        for (int it = 0; it < 40; it++) begin
            tick(5);
            elapsed += 5;
            if ($urandom_range(0, 2) == 0) begin
                result_ack = 1'b1;
                tick();
                result_ack = 1'b0;
                elapsed++;
                mReady = 1'b0;
                checkOutput($sformatf("rnd_ack%0d", it), result_ready, 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                mShadow = $urandom_range(0, 3);
                cfg_average = 4'(mShadow); cfg_load = 1'b1;
                tick();
                cfg_load = 1'b0;
                elapsed++;
            end
            if ($urandom_range(0, 3) == 0) begin
                g = $urandom_range(15, 40);
                tick(g - elapsed);
                applyStimulus();
                elapsed = g + 3;
                if (mGlitch < 255) mGlitch++;
                checkOutput($sformatf("rnd_glitch_clr%0d", it), counter_clear, 0);
                checkOutput($sformatf("rnd_glitch_cnt%0d", it), glitch_count, mGlitch);
            end
            gap = $urandom_range(90, 110);
            tick(gap - elapsed);
            applyStimulus();
            elapsed = 3;
            mIntervals++;
            if (mIntervals == mActive + 1) begin
                expClear = 1'b1; expLatch = 1'b1;
                mIntervals = 0; mActive = mShadow;
                if (mReady) mOverrun = 1'b1;
                mReady = 1'b1;
            end else begin
                expClear = 1'b0; expLatch = 1'b0;
            end
            checkOutput($sformatf("rnd_latch%0d", it), counter_latch, expLatch);
            checkOutput($sformatf("rnd_clear%0d", it), counter_clear, expClear);
            checkOutput($sformatf("rnd_ready%0d", it), result_ready, mReady);
        end
        tick(2);
        checkOutput("rnd_glitch_final", glitch_count, mGlitch);
        checkOutput("rnd_overrun_final", overrun, mOverrun);
        checkOutput("rnd_state_final", state, 2);
        checkOutput("rnd_missing_final", pps_missing, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gps_gate_controller.md
# gps_gate_controller

Sequences the GPS-disciplined frequency-measurement gate. Sits between the synchronised GPS_PULSE input, the 36-bit reference-clock counter and the SPI register file. Opens and closes measurement gates spanning a configurable number of PPS intervals, and rejects glitch pulses. Detects loss of PPS and hands latched results to the SPI side with a ready/ack handshake and overrun detection.

## Interface
Parameters:
- TIMER_WIDTH, 25, width of the interval timer (saturating).
- MIN_PERIOD_CYCLES, 8_000_000, minimum system_clk cycles between accepted PPS edges.
- TIMEOUT_CYCLES, 12_000_000, cycles without an accepted edge before PPS is declared missing.

Ports:
- system_clk, in, 1, sole clock; all logic on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- gps_pulse, in, 1, raw PPS pin (asynchronous).
- enable, in, 1, measurement run enable (level).
- cfg_average, in, 4, gate length minus one, in PPS intervals.
- cfg_load, in, 1, one-cycle strobe capturing cfg_average into the shadow register.
- result_ack, in, 1, one-cycle strobe from the SPI side (value_valid).
- status_clear, in, 1, one-cycle strobe clearing the sticky flags.
- counter_enable, out, 1, counter increments while high.
- counter_clear, out, 1, one-cycle pulse zeroing the counter.
- counter_latch, out, 1, one-cycle pulse copying the counter into the result register.
- result_ready, out, 1, a latched result awaits readout.
- overrun, out, 1, sticky: a result was overwritten before ack.
- pps_missing, out, 1, sticky: timeout expired.
- glitch_count, out, 8, saturating count of rejected edges.
- state, out, 2, current FSM state (IDLE=0, ARM=1, MEASURE=2).

## Operation
- gps_pulse passes through a 2-FF synchroniser followed by a third register. pps_edge = sync & ~prev.
- Interval timer:
  - cleared on each accepted edge, otherwise +1, saturating at all-ones.
  - held at 0 in IDLE.
- Accepted edge:
  - ARM: any pps_edge is accepted.
  - MEASURE: pps_edge is accepted only if timer >= MIN_PERIOD_CYCLES.
  - An edge in MEASURE with timer below the limit is rejected; glitch_count += 1, saturating at 255.
- FSM:
  - IDLE: all strobes low, counter_enable=0. Goes to ARM when enable=1.
  - ARM: waits for an accepted edge. On that edge: counter_clear pulses, edge_count=0, active_average <= shadow, go to MEASURE.
  - MEASURE: counter_enable=1. On each accepted edge:
    - if edge_count == active_average: counter_latch and counter_clear pulse together, result_ready <= 1, edge_count <= 0, active_average <= shadow.
    - else edge_count += 1.
  - A gate therefore spans active_average+1 PPS intervals (cfg_average=0 means a 1 s gate).
  - Timeout: in MEASURE with timer == TIMEOUT_CYCLES, set pps_missing, go to ARM, counter_enable drops, no latch. The partial gate is discarded.
  - enable=0 in any state forces IDLE next cycle. The partial gate is discarded, with no latch.
- Config:
  - cfg_load writes the shadow register at any time.
  - The new value takes effect only at the next gate start or boundary, never mid-gate.
- Handshake:
  - result_ready is set by counter_latch and cleared by result_ack.
  - If latch and ack occur in the same cycle, result_ready stays 1 and overrun is not set.
  - If latch occurs while result_ready=1 and no ack arrives that cycle, overrun <= 1.
- Sticky flags:
  - status_clear zeroes overrun, pps_missing and glitch_count.
  - A set condition in the same cycle as status_clear wins.

## Timing
- Reset values:
  - all outputs 0, state=IDLE.
  - shadow=0, active_average=0, edge_count=0, timer=0, synchroniser=0.
- Edge latency: gps_pulse rise is detected as pps_edge at the 3rd rising system_clk edge after the rise. counter_clear/counter_latch are registered and high during the cycle after pps_edge.
- All strobe outputs are exactly one cycle wide.
- counter_enable and state are registered and change in the same cycle as the strobes.
- result_ready rises in the same cycle as counter_latch and falls the cycle after result_ack.
- The ready/overrun logic evaluates the registered counter_latch together with result_ack of the same cycle.
- Reset asserted mid-gate returns every register to its reset value immediately (asynchronously), with no latch.

## Structure
- Shared package gps_pkg holds:
  - the state encoding (IDLE/ARM/MEASURE as a 2-bit typedef),
  - GLITCH_COUNT_WIDTH=8,
  - the default MIN_PERIOD/TIMEOUT constants, used here and by the top level.
- One sub-module, pulse_synchronizer: 2-FF synchroniser plus rising-edge detect, with system_clk and rst_n. It is reused for other asynchronous inputs.
- Interval timer, FSM and handshake stay in gps_gate_controller.

## Test plan
- Startup: reset, enable=1, cfg_load cfg_average=2, PPS every 10M cycles → clear at 1st edge; latch+clear at 4th edge; result_ready=1; state=MEASURE.
- Glitch: extra pulse 1M cycles after an accepted edge → glitch_count=1, edge_count unchanged, next 10M-spaced edge is accepted normally.
- Timeout: stop PPS in MEASURE → pps_missing=1 at timer==TIMEOUT_CYCLES, state=ARM, counter_enable=0, no latch. Resumed PPS restarts the gate with a clear.
- Overrun: cfg_average=0, no ack across two gates → overrun=1 at the second latch. A repeat with ack in the latch cycle → result_ready=1, overrun=0.
- Config timing: cfg_load 5 mid-gate with active 1 → current gate ends after 2 intervals, next gate after 6.
- Abort: enable=0, or rst_n low mid-gate → IDLE, all outputs 0, no counter_latch pulse.
